// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares the read and write ports of the data memory between NREQ
//   requesters. Arbitration is round-robin, with one transaction in flight at
//   a time. A requester that holds lock and req through its ack keeps the
//   grant and goes straight into its next access.
//
// Ports
//   clock, reset         system clock, asynchronous active-low reset
//   req/lock/we          per-requester request, keep-grant and write select
//   addr/wdata           flattened per-requester address / write data
//   gnt/ack              one-hot owner and one-cycle completion pulse
//   rdata                last captured read result
//   busy                 arbiter is not idle
//   mem_rd_addr/data     memory read port
//   mem_wr_addr/data/en  memory write port
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no owner; pick the next requester round-robin
// ST_ISSUE | drive the latched access onto the memory port for one cycle
// ST_WAIT  | read in flight; count down the remaining memory latency
// ST_ACK   | pulse ack to the owner; re-issue if it is locked
module data_mem_arbiter #(
  parameter int NREQ       = 3,
  parameter int AW         = 9,
  parameter int DW         = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    lock,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    ack,
  output logic [DW-1:0]      rdata,
  output logic               busy,
  output logic [AW-1:0]      mem_rd_addr,
  input  logic [DW-1:0]      mem_rd_data,
  output logic [AW-1:0]      mem_wr_addr,
  output logic [DW-1:0]      mem_wr_data,
  output logic               mem_wr_enable
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            we_q, we_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            busy_q, busy_d;
  logic [AW-1:0]   mem_rd_addr_q, mem_rd_addr_d;
  logic [AW-1:0]   mem_wr_addr_q, mem_wr_addr_d;
  logic [DW-1:0]   mem_wr_data_q, mem_wr_data_d;
  logic            mem_wr_enable_q, mem_wr_enable_d;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  logic            grant_go;
  logic [IW-1:0]   grant_idx;
  logic [AW-1:0]   grant_addr;
  logic [DW-1:0]   grant_wdata;

  // Round-robin scan starting just after the last owner, wrapping at NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == IW'(NREQ - 1)) ? '0 : cand + IW'(1);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    ptr_d           = ptr_q;
    we_d            = we_q;
    cnt_d           = cnt_q;
    gnt_d           = gnt_q;
    ack_d           = '0;
    rdata_d         = rdata_q;
    mem_rd_addr_d   = mem_rd_addr_q;
    mem_wr_addr_d   = mem_wr_addr_q;
    mem_wr_data_d   = mem_wr_data_q;
    mem_wr_enable_d = 1'b0;
    grant_go        = 1'b0;
    grant_idx       = owner_q;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          grant_go  = 1'b1;
          grant_idx = win_idx;
          ptr_d     = win_idx;
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_d = ST_ACK;
          ack_d   = gnt_q;
        end else if (RD_LATENCY == 1) begin
          rdata_d = mem_rd_data;
          state_d = ST_ACK;
          ack_d   = gnt_q;
        end else begin
          cnt_d   = CW'(RD_LATENCY - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= CW'(1)) begin
          rdata_d = mem_rd_data;
          state_d = ST_ACK;
          ack_d   = gnt_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_ACK: begin
        // A locked owner skips IDLE so no other requester can slip in.
        if (lock[owner_q] && req[owner_q]) begin
          grant_go  = 1'b1;
          grant_idx = owner_q;
        end else begin
          gnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // The memory port registers double as the latched request: address and
    // data are placed on the port at grant so they are stable through ISSUE.
    grant_addr  = AW'(addr >> (int'(grant_idx) * AW));
    grant_wdata = DW'(wdata >> (int'(grant_idx) * DW));
    if (grant_go) begin
      owner_d = grant_idx;
      we_d    = we[grant_idx];
      gnt_d   = NREQ'(1) << grant_idx;
      state_d = ST_ISSUE;
      if (we[grant_idx]) begin
        mem_wr_enable_d = 1'b1;
        mem_wr_addr_d   = grant_addr;
        mem_wr_data_d   = grant_wdata;
      end else begin
        mem_rd_addr_d = grant_addr;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      owner_q         <= '0;
      ptr_q           <= IW'(NREQ - 1);
      we_q            <= 1'b0;
      cnt_q           <= '0;
      gnt_q           <= '0;
      ack_q           <= '0;
      rdata_q         <= '0;
      busy_q          <= 1'b0;
      mem_rd_addr_q   <= '0;
      mem_wr_addr_q   <= '0;
      mem_wr_data_q   <= '0;
      mem_wr_enable_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      ptr_q           <= ptr_d;
      we_q            <= we_d;
      cnt_q           <= cnt_d;
      gnt_q           <= gnt_d;
      ack_q           <= ack_d;
      rdata_q         <= rdata_d;
      busy_q          <= busy_d;
      mem_rd_addr_q   <= mem_rd_addr_d;
      mem_wr_addr_q   <= mem_wr_addr_d;
      mem_wr_data_q   <= mem_wr_data_d;
      mem_wr_enable_q <= mem_wr_enable_d;
    end
  end

  assign gnt           = gnt_q;
  assign ack           = ack_q;
  assign rdata         = rdata_q;
  assign busy          = busy_q;
  assign mem_rd_addr   = mem_rd_addr_q;
  assign mem_wr_addr   = mem_wr_addr_q;
  assign mem_wr_data   = mem_wr_data_q;
  assign mem_wr_enable = mem_wr_enable_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a RD_LATENCY=1 instance (u_dut) and a
// RD_LATENCY=3 instance (u_dut3), each with its own memory model.
module tb_data_mem_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 9;
  localparam int DW   = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- instance with RD_LATENCY = 1 ----------------
  logic [NREQ-1:0]    req = '0, lock = '0, we = '0;
  logic [NREQ*AW-1:0] addr = '0;
  logic [NREQ*DW-1:0] wdata = '0;
  logic [NREQ-1:0]    gnt, ack;
  logic [DW-1:0]      rdata, mrd_data, mwr_data;
  logic               busy, mwr_en;
  logic [AW-1:0]      mrd_addr, mwr_addr;
  logic [DW-1:0]      mem1 [512];

  data_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LATENCY(1)) u_dut (
    .clock(clk), .reset(rst_n), .req(req), .lock(lock), .we(we), .addr(addr),
    .wdata(wdata), .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy),
    .mem_rd_addr(mrd_addr), .mem_rd_data(mrd_data), .mem_wr_addr(mwr_addr),
    .mem_wr_data(mwr_data), .mem_wr_enable(mwr_en));

  // ---------------- instance with RD_LATENCY = 3 ----------------
  logic [NREQ-1:0]    req3 = '0, lock3 = '0, we3 = '0;
  logic [NREQ*AW-1:0] addr3 = '0;
  logic [NREQ*DW-1:0] wdata3 = '0;
  logic [NREQ-1:0]    gnt3, ack3;
  logic [DW-1:0]      rdata3, mrd_data3, mwr_data3;
  logic               busy3, mwr_en3;
  logic [AW-1:0]      mrd_addr3, mwr_addr3;
  logic [DW-1:0]      mem3 [512];
  logic [AW-1:0]      rd_pipe1 = '0, rd_pipe2 = '0;

  data_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LATENCY(3)) u_dut3 (
    .clock(clk), .reset(rst_n), .req(req3), .lock(lock3), .we(we3), .addr(addr3),
    .wdata(wdata3), .gnt(gnt3), .ack(ack3), .rdata(rdata3), .busy(busy3),
    .mem_rd_addr(mrd_addr3), .mem_rd_data(mrd_data3), .mem_wr_addr(mwr_addr3),
    .mem_wr_data(mwr_data3), .mem_wr_enable(mwr_en3));

  // Memory models: every word starts as A5000000 | index; mem3[1FF] is preset.
  bit mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 512; i++) begin
        mem1[i] <= 32'hA500_0000 | 32'(i);
        mem3[i] <= (i == 511) ? 32'h1234_5678 : (32'hA500_0000 | 32'(i));
      end
      mem_ready <= 1'b1;
    end else begin
      if (mwr_en)  mem1[mwr_addr]  <= mwr_data;
      if (mwr_en3) mem3[mwr_addr3] <= mwr_data3;
    end
  end
  assign mrd_data = mem1[mrd_addr];
  // Three-cycle read: data for the address presented in cycle n shows in n+2.
  always @(posedge clk) begin
    rd_pipe1 <= mrd_addr3;
    rd_pipe2 <= rd_pipe1;
  end
  assign mrd_data3 = mem3[rd_pipe2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [1:0] i, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = r;
    we[i]  = w;
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic drive_b(input logic [1:0] i, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req3[i] = r;
    we3[i]  = w;
    addr3[i*AW +: AW]  = a;
    wdata3[i*DW +: DW] = d;
  endtask

  // All three read together from idle: grants/acks in slots of three cycles.
  task automatic contention_round();
    logic [DW-1:0] exp_rd [3];
    exp_rd[0] = 32'hA500_0005;
    exp_rd[1] = 32'hA500_0006;
    exp_rd[2] = 32'hA500_01FF;
    drive_a(2'd0, 1'b1, 1'b0, 9'h005, '0);
    drive_a(2'd1, 1'b1, 1'b0, 9'h006, '0);
    drive_a(2'd2, 1'b1, 1'b0, 9'h1FF, '0);
    for (int c = 1; c <= 9; c++) begin
      int slot;
      int pos;
      logic [2:0] eg, ea;
      slot = (c - 1) / 3;
      pos  = (c - 1) % 3;
      tick();
      eg = (pos < 2)  ? (3'b001 << slot) : 3'b000;
      ea = (pos == 1) ? (3'b001 << slot) : 3'b000;
      chk("cont_gnt", 64'(gnt), 64'(eg));
      chk("cont_ack", 64'(ack), 64'(ea));
      if (pos == 1) begin
        chk("cont_rdata", 64'(rdata), 64'(exp_rd[slot]));
        drive_a(2'(slot), 1'b0, 1'b0, '0, '0);
      end
    end
  endtask

  typedef struct {
    logic [1:0]    idx;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  // Random-phase reference state
  logic [DW-1:0] ref_mem [8];
  logic [2:0]    r_a [NREQ];
  logic [DW-1:0] r_d [NREQ];
  logic [2:0]    a_p [NREQ];
  logic [DW-1:0] d_p [NREQ];

  initial begin
    vecs[0] = '{2'd0, 1'b1, 9'h005, 32'hDEAD_BEEF, 32'hA500_01FF};
    vecs[1] = '{2'd1, 1'b1, 9'h006, 32'hCAFE_F00D, 32'hA500_01FF};
    vecs[2] = '{2'd2, 1'b1, 9'h1FF, 32'h1234_5678, 32'hA500_01FF};
    vecs[3] = '{2'd2, 1'b0, 9'h005, 32'h0,         32'hDEAD_BEEF};
    vecs[4] = '{2'd0, 1'b0, 9'h006, 32'h0,         32'hCAFE_F00D};
    vecs[5] = '{2'd1, 1'b0, 9'h1FF, 32'h0,         32'h1234_5678};
    vecs[6] = '{2'd1, 1'b1, 9'h005, 32'h0000_0001, 32'h1234_5678};
    vecs[7] = '{2'd0, 1'b0, 9'h005, 32'h0,         32'h0000_0001};

    // ---- reset state ----
    #2;
    chk("rst_gnt",   64'(gnt),    64'(0));
    chk("rst_ack",   64'(ack),    64'(0));
    chk("rst_busy",  64'(busy),   64'(0));
    chk("rst_wren",  64'(mwr_en), 64'(0));
    chk("rst_rdata", 64'(rdata),  64'(0));
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick();

    // ---- contention, two rounds, both starting with requester 0 ----
    contention_round();
    contention_round();

    // ---- single-requester table ----
    for (int v = 0; v < 8; v++) begin
      drive_a(vecs[v].idx, 1'b1, vecs[v].w, vecs[v].a, vecs[v].d);
      tick();
      chk("tbl_gnt", 64'(gnt), 64'(3'b001 << vecs[v].idx));
      chk("tbl_wren", 64'(mwr_en), 64'(vecs[v].w));
      if (vecs[v].w) begin
        chk("tbl_wr_addr", 64'(mwr_addr), 64'(vecs[v].a));
        chk("tbl_wr_data", 64'(mwr_data), 64'(vecs[v].d));
      end else begin
        chk("tbl_rd_addr", 64'(mrd_addr), 64'(vecs[v].a));
      end
      tick();
      chk("tbl_ack",   64'(ack),    64'(3'b001 << vecs[v].idx));
      chk("tbl_rdata", 64'(rdata),  64'(vecs[v].exp_rdata));
      chk("tbl_wren2", 64'(mwr_en), 64'(0));
      drive_a(vecs[v].idx, 1'b0, 1'b0, '0, '0);
      tick();
      chk("tbl_idle_busy", 64'(busy), 64'(0));
      chk("tbl_idle_gnt",  64'(gnt),  64'(0));
    end

    // ---- locked write stream from requester 1 with requester 2 pending ----
    drive_a(2'd1, 1'b1, 1'b1, 9'h010, 32'h1111_0010);
    lock[1] = 1'b1;
    drive_a(2'd2, 1'b1, 1'b0, 9'h005, '0);
    tick();
    chk("lock_gnt1",  64'(gnt),      64'(3'b010));
    chk("lock_wren1", 64'(mwr_en),   64'(1));
    chk("lock_wa1",   64'(mwr_addr), 64'(9'h010));
    tick();
    chk("lock_ack1",  64'(ack),      64'(3'b010));
    drive_a(2'd1, 1'b1, 1'b1, 9'h011, 32'h1111_0011);
    tick();
    chk("lock_gnt_kept", 64'(gnt),      64'(3'b010));
    chk("lock_wren2",    64'(mwr_en),   64'(1));
    chk("lock_wa2",      64'(mwr_addr), 64'(9'h011));
    chk("lock_wd2",      64'(mwr_data), 64'(32'h1111_0011));
    chk("lock_noack",    64'(ack),      64'(0));
    tick();
    chk("lock_ack2", 64'(ack), 64'(3'b010));
    lock[1] = 1'b0;
    drive_a(2'd1, 1'b0, 1'b0, '0, '0);
    tick();
    chk("lock_idle_gnt", 64'(gnt), 64'(0));
    tick();
    chk("lock_gnt2", 64'(gnt), 64'(3'b100));
    tick();
    chk("lock_ack_r2",   64'(ack),   64'(3'b100));
    chk("lock_rdata_r2", 64'(rdata), 64'(32'h0000_0001));
    drive_a(2'd2, 1'b0, 1'b0, '0, '0);
    tick();
    chk("lock_mem010", 64'(mem1[9'h010]), 64'(32'h1111_0010));
    chk("lock_mem011", 64'(mem1[9'h011]), 64'(32'h1111_0011));

    // ---- read latency 3 ----
    drive_b(2'd0, 1'b1, 1'b0, 9'h1FF, '0);
    tick();
    chk("lat_gnt",  64'(gnt3),      64'(3'b001));
    chk("lat_ra",   64'(mrd_addr3), 64'(9'h1FF));
    chk("lat_ack1", 64'(ack3),      64'(0));
    tick();
    chk("lat_ack2",  64'(ack3),  64'(0));
    chk("lat_busy2", 64'(busy3), 64'(1));
    tick();
    chk("lat_ack3",  64'(ack3),  64'(0));
    chk("lat_busy3", 64'(busy3), 64'(1));
    tick();
    chk("lat_ack4",   64'(ack3),   64'(3'b001));
    chk("lat_rdata4", 64'(rdata3), 64'(32'h1234_5678));
    drive_b(2'd0, 1'b0, 1'b0, '0, '0);
    tick();
    chk("lat_idle", 64'(busy3), 64'(0));

    // ---- reset mid-transaction: u_dut3 in WAIT, u_dut in write ISSUE ----
    drive_b(2'd0, 1'b1, 1'b0, 9'h1FF, '0);
    tick();
    drive_a(2'd0, 1'b1, 1'b1, 9'h0F0, 32'hBAD0_BAD0);
    tick();
    chk("mid_pre_wren", 64'(mwr_en), 64'(1));
    chk("mid_pre_busy", 64'(busy3),  64'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_gnt",    64'(gnt),    64'(0));
    chk("mid_wren",   64'(mwr_en), 64'(0));
    chk("mid_busy",   64'(busy),   64'(0));
    chk("mid_rdata",  64'(rdata),  64'(0));
    chk("mid_gnt3",   64'(gnt3),   64'(0));
    chk("mid_ack3",   64'(ack3),   64'(0));
    chk("mid_busy3",  64'(busy3),  64'(0));
    chk("mid_rdata3", 64'(rdata3), 64'(0));
    drive_a(2'd0, 1'b0, 1'b0, '0, '0);
    drive_b(2'd0, 1'b0, 1'b0, '0, '0);
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("post_rst_ack3", 64'(ack3), 64'(0));
      chk("post_rst_ack",  64'(ack),  64'(0));
    end
    chk("dropped_write", 64'(mem1[9'h0F0]), 64'(32'hA500_00F0));
    drive_b(2'd2, 1'b1, 1'b0, 9'h1FF, '0);
    tick();
    chk("post_rst_gnt3", 64'(gnt3), 64'(3'b100));
    tick(); tick(); tick();
    chk("post_rst_ack3_r2", 64'(ack3),   64'(3'b100));
    chk("post_rst_rdata3",  64'(rdata3), 64'(32'h1234_5678));
    drive_b(2'd2, 1'b0, 1'b0, '0, '0);
    tick();

    // ---- randomized traffic on u_dut against a transaction-level model ----
    begin
      int t, t_iss, t_ack, ptr_m, owner;
      logic m_we;
      logic [2:0] m_a;
      logic [NREQ-1:0] req_p, we_p;
      logic [2:0] eg;
      t = 0; t_iss = -10; t_ack = -10; ptr_m = NREQ - 1; owner = 0;
      m_we = 1'b0; m_a = '0;
      for (int i = 0; i < 8; i++) ref_mem[i] = 32'hA500_0080 + 32'(i);
      for (int i = 0; i < NREQ; i++) begin
        r_a[i] = '0;
        r_d[i] = '0;
      end
      for (int cyc = 0; cyc < 400; cyc++) begin
        req_p = req;
        we_p  = we;
        for (int i = 0; i < NREQ; i++) begin
          a_p[i] = r_a[i];
          d_p[i] = r_d[i];
        end
        tick();
        t++;
        // An idle cycle with any request present starts a transaction.
        if (t - 1 > t_ack && req_p != '0) begin
          for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (ptr_m + k) % NREQ;
            if (req_p[2'(c)]) begin
              owner = c;
              break;
            end
          end
          ptr_m = owner;
          m_we  = we_p[2'(owner)];
          m_a   = a_p[owner];
          t_iss = t;
          t_ack = t + 1;
          if (m_we) ref_mem[m_a] = d_p[owner];
        end
        eg = (t >= t_iss && t <= t_ack) ? (3'b001 << owner) : 3'b000;
        chk("rnd_gnt",  64'(gnt),  64'(eg));
        chk("rnd_ack",  64'(ack),  64'((t == t_ack) ? (3'b001 << owner) : 3'b000));
        chk("rnd_busy", 64'(busy), 64'(t >= t_iss && t <= t_ack));
        chk("rnd_wren", 64'(mwr_en), 64'(m_we && t == t_iss));
        if (m_we && t == t_iss) begin
          chk("rnd_wa", 64'(mwr_addr), 64'({6'b010000, m_a}));
          chk("rnd_wd", 64'(mwr_data), 64'(ref_mem[m_a]));
        end
        if (!m_we && t == t_ack)
          chk("rnd_rdata", 64'(rdata), 64'(ref_mem[m_a]));
        if (t == t_ack) drive_a(2'(owner), 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < NREQ; i++) begin
          if (!req[2'(i)] && $urandom_range(0, 2) == 0) begin
            r_a[i] = 3'($urandom_range(0, 7));
            r_d[i] = $urandom;
            drive_a(2'(i), 1'b1, 1'($urandom_range(0, 1)), {6'b010000, r_a[i]}, r_d[i]);
          end
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
